// File: rtl/timer_ctrl.sv
// Countdown-timer controller for the M:SS seven-segment display path.
// Holds minutes / tens-of-seconds / seconds as BCD digits and counts them
// down once per prescaled tick, sequenced by a four-state FSM.
// Optional feature macro: TIMER_BLINK_EN. When it is defined, the digits
// alternate between 4'hF (blanked by the decoder) and 0:00 while in DONE.
module timer_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LP_TOP = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_min;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_running;
    logic             r_done;

    logic             w_cnt_en;
    logic             w_tick;
    logic             w_load_ok;
    logic             w_zero;
    logic             w_last;
    logic             w_dec;

`ifdef TIMER_BLINK_EN
    logic             r_blank;
`endif

    // Clamp a preset digit to its legal maximum.
    function automatic logic [3:0] f_sat(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One-second BCD decrement with borrow from seconds to tens to minutes.
    function automatic logic [11:0] f_dec(input logic [3:0] m, input logic [3:0] t,
                                          input logic [3:0] o);
        if (o != 4'd0)
            return {m, t, o - 4'd1};
        else if (t != 4'd0)
            return {m, t - 4'd1, 4'd9};
        else
            return {m - 4'd1, 4'd5, 4'd9};
    endfunction

    assign w_zero    = ({r_min, r_tens, r_ones} == 12'h000);
    assign w_last    = ({r_min, r_tens, r_ones} == 12'h001);
    // Load is only honoured while the timer is not counting.
    assign w_load_ok = load && ((r_state == S_IDLE) || (r_state == S_DONE));
`ifdef TIMER_BLINK_EN
    assign w_cnt_en  = (r_state == S_RUN) || (r_state == S_DONE);
`else
    assign w_cnt_en  = (r_state == S_RUN);
`endif
    assign w_tick    = w_cnt_en && (r_cnt == LP_TOP);
    // A stop on the tick cycle discards that tick.
    assign w_dec     = (r_state == S_RUN) && w_tick && !stop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic with priority clear > load > stop > start.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else if (w_load_ok) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start && !w_zero) w_next = S_RUN;
                S_RUN: begin
                    if (stop)
                        w_next = S_PAUSE;
                    else if (w_tick && w_last)
                        w_next = S_DONE;
                end
                S_PAUSE: if (start) w_next = S_RUN;
                S_DONE:  w_next = S_DONE;
            endcase
        end
    end

    // Prescaler: runs while counting, holds in PAUSE so resume keeps the sub-second phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clear || w_load_ok)
            r_cnt <= '0;
        else if ((r_state == S_IDLE) && (w_next == S_RUN))
            r_cnt <= '0;
        else if (w_cnt_en)
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end

    // Digit registers: clear, saturating preset, per-tick decrement (and blink in DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {r_min, r_tens, r_ones} <= 12'h000;
        else if (clear)
            {r_min, r_tens, r_ones} <= 12'h000;
        else if (w_load_ok)
            {r_min, r_tens, r_ones} <= {f_sat(load_min, 4'd9),
                                        f_sat(load_sec_tens, 4'd5),
                                        f_sat(load_sec_ones, 4'd9)};
        else if (w_dec)
            {r_min, r_tens, r_ones} <= w_last ? 12'h000 : f_dec(r_min, r_tens, r_ones);
`ifdef TIMER_BLINK_EN
        else if ((r_state == S_DONE) && w_tick)
            {r_min, r_tens, r_ones} <= r_blank ? 12'h000 : 12'hFFF;
`endif
    end

`ifdef TIMER_BLINK_EN
    // Blank flag toggles on each tick in DONE and drops as soon as DONE is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_blank <= 1'b0;
        else if (w_next != S_DONE)
            r_blank <= 1'b0;
        else if ((r_state == S_DONE) && w_tick)
            r_blank <= ~r_blank;
    end
`endif

    // Registered status: running mirrors RUN, done pulses on the RUN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_running <= (w_next == S_RUN);
            r_done    <= (r_state == S_RUN) && (w_next == S_DONE);
        end
    end

    assign min      = r_min;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
    assign running  = r_running;
    assign done     = r_done;

endmodule
